// File: rtl/frame_top2_reporter.sv
// Per-frame top-two reporter: tracks the largest and second-largest unsigned
// sample plus a saturating beat count, and publishes one summary per frame.
module frame_top2_reporter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_largest,
  output logic [DATA_WIDTH-1:0] m_second,
  output logic [CNT_WIDTH-1:0]  m_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_load;
  logic                  w_accept;

  logic [DATA_WIDTH-1:0] r_acc_largest;
  logic [DATA_WIDTH-1:0] r_acc_second;
  logic [CNT_WIDTH-1:0]  r_acc_count;
  logic [DATA_WIDTH-1:0] w_acc_largest_nxt;
  logic [DATA_WIDTH-1:0] w_acc_second_nxt;
  logic [CNT_WIDTH-1:0]  w_acc_count_nxt;

  logic [DATA_WIDTH-1:0] r_largest;
  logic [DATA_WIDTH-1:0] r_second;
  logic [CNT_WIDTH-1:0]  r_count;

  // Ready depends only on the registered summary slot, never on s_valid.
  assign s_ready   = (r_state == ST_EMPTY) || m_ready;
  assign w_accept  = s_valid && s_ready;
  assign m_valid   = (r_state == ST_FULL);
  assign m_largest = r_largest;
  assign m_second  = r_second;
  assign m_count   = r_count;

  // Accumulator values after applying the current beat.
  always_comb begin
    w_acc_largest_nxt = r_acc_largest;
    w_acc_second_nxt  = r_acc_second;
    w_acc_count_nxt   = r_acc_count;
    if (s_data > r_acc_largest) begin
      w_acc_second_nxt  = r_acc_largest;
      w_acc_largest_nxt = s_data;
    end else if (s_data > r_acc_second) begin
      w_acc_second_nxt = s_data;
    end
    if (r_acc_count != CNT_MAX) begin
      w_acc_count_nxt = r_acc_count + CNT_WIDTH'(1);
    end
  end

  // Output slot FSM: a last beat may refill the slot in the cycle it drains.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept && s_last) begin
          w_state_nxt = ST_FULL;
          w_load      = 1'b1;
        end
      end
      ST_FULL: begin
        if (w_accept && s_last) begin
          w_load = 1'b1;
        end else if (m_ready) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_EMPTY;
      r_acc_largest <= '0;
      r_acc_second  <= '0;
      r_acc_count   <= '0;
      r_largest     <= '0;
      r_second      <= '0;
      r_count       <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_largest <= w_acc_largest_nxt;
        r_second  <= w_acc_second_nxt;
        r_count   <= w_acc_count_nxt;
      end
      if (w_accept) begin
        if (s_last) begin
          r_acc_largest <= '0;
          r_acc_second  <= '0;
          r_acc_count   <= '0;
        end else begin
          r_acc_largest <= w_acc_largest_nxt;
          r_acc_second  <= w_acc_second_nxt;
          r_acc_count   <= w_acc_count_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_top2_reporter.sv
// Bench for frame_top2_reporter: directed vector table, a saturating-count
// instance, and randomized traffic against a frame-level reference model.
module tb_frame_top2_reporter;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid, s_ready, s_last, m_valid, m_ready;
  logic [31:0] s_data, m_largest, m_second;
  logic [15:0] m_count;

  logic        s2_valid, s2_ready, s2_last, m2_valid;
  logic [31:0] s2_data, m2_largest, m2_second;
  logic [1:0]  m2_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  frame_top2_reporter #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
    .m_largest(m_largest), .m_second(m_second), .m_count(m_count)
  );

  frame_top2_reporter #(.DATA_WIDTH(32), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .reset(reset), .s_valid(s2_valid), .s_ready(s2_ready),
    .s_data(s2_data), .s_last(s2_last), .m_valid(m2_valid), .m_ready(1'b1),
    .m_largest(m2_largest), .m_second(m2_second), .m_count(m2_count)
  );

  typedef struct {
    bit          rst;
    bit          v;
    logic [31:0] d;
    bit          l;
    bit          mr;
    bit          emv;
    logic [31:0] el;
    logic [31:0] es;
    logic [15:0] ec;
  } vec_t;

  vec_t vecs[24];

  // Reference model: samples of the open frame plus the published summary.
  int unsigned frame_q[$];
  bit          o_full;
  logic [31:0] o_l, o_s;
  logic [15:0] o_c;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(bit rst, bit v, int unsigned d, bit l, bit mr,
                              bit emv, int unsigned el, int unsigned es, int unsigned ec);
    vec_t t;
    t.rst = rst; t.v = v; t.d = 32'(d); t.l = l; t.mr = mr;
    t.emv = emv; t.el = 32'(el); t.es = 32'(es); t.ec = 16'(ec);
    return t;
  endfunction

  task automatic model_clear();
    frame_q.delete();
    o_full = 1'b0;
    o_l = '0; o_s = '0; o_c = '0;
  endtask

  // Summary of a completed frame: top two by value (duplicates count).
  task automatic summarize();
    int unsigned big, sec;
    int          idx;
    big = 0; sec = 0; idx = 0;
    for (int i = 0; i < frame_q.size(); i++)
      if (frame_q[i] >= big) begin big = frame_q[i]; idx = i; end
    for (int i = 0; i < frame_q.size(); i++)
      if (i != idx && frame_q[i] > sec) sec = frame_q[i];
    o_l = 32'(big);
    o_s = 32'(sec);
    o_c = (frame_q.size() > 65535) ? 16'hFFFF : 16'(frame_q.size());
  endtask

  task automatic step(input bit rst, input bit v, input logic [31:0] d, input bit l, input bit mr);
    bit exp_ready;
    reset = rst; s_valid = v; s_data = d; s_last = l; m_ready = mr;
    @(negedge clk);
    exp_ready = !o_full || mr;
    check("s_ready", 64'(s_ready), 64'(exp_ready));
    if (rst) begin
      model_clear();
    end else begin
      if (v && exp_ready) frame_q.push_back(int'(d));
      if (v && exp_ready && l) begin
        summarize();
        frame_q.delete();
        o_full = 1'b1;
      end else if (o_full && mr) begin
        o_full = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check("m_valid", 64'(m_valid), 64'(o_full));
    check("m_largest", 64'(m_largest), 64'(o_l));
    check("m_second", 64'(m_second), 64'(o_s));
    check("m_count", 64'(m_count), 64'(o_c));
  endtask

  initial begin
    reset = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
    s2_valid = 1'b0; s2_data = '0; s2_last = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_largest", 64'(m_largest), 64'd0);
    check("rst_m_second", 64'(m_second), 64'd0);
    check("rst_m_count", 64'(m_count), 64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd1);
    reset = 1'b0;

    // Saturating count with a 2-bit counter: beats 1..6.
    for (int i = 1; i <= 6; i++) begin
      s2_valid = 1'b1; s2_data = 32'(i); s2_last = (i == 6);
      @(posedge clk);
      #1;
    end
    s2_valid = 1'b0; s2_last = 1'b0;
    check("sat_m_valid", 64'(m2_valid), 64'd1);
    check("sat_m_count", 64'(m2_count), 64'd3);
    check("sat_m_largest", 64'(m2_largest), 64'd6);
    check("sat_m_second", 64'(m2_second), 64'd5);

    //            rst v  d   l  mr  emv  L   S  C
    vecs[0]  = mk(0, 1,  3, 0, 1,  0,  0,  0, 0);
    vecs[1]  = mk(0, 1,  7, 0, 1,  0,  0,  0, 0);
    vecs[2]  = mk(0, 1,  5, 1, 1,  1,  7,  5, 3);
    vecs[3]  = mk(0, 1,  9, 0, 1,  0,  7,  5, 3);
    vecs[4]  = mk(0, 1,  9, 0, 1,  0,  7,  5, 3);
    vecs[5]  = mk(0, 1,  2, 1, 1,  1,  9,  9, 3);
    vecs[6]  = mk(0, 1,  1, 1, 1,  1,  1,  0, 1);
    vecs[7]  = mk(0, 0,  0, 0, 0,  1,  1,  0, 1);
    vecs[8]  = mk(0, 0,  0, 0, 1,  0,  1,  0, 1);
    vecs[9]  = mk(0, 1,  4, 0, 1,  0,  1,  0, 1);
    vecs[10] = mk(0, 1,  6, 1, 0,  1,  6,  4, 2);
    vecs[11] = mk(0, 1,  8, 1, 0,  1,  6,  4, 2);
    vecs[12] = mk(0, 1,  8, 1, 0,  1,  6,  4, 2);
    vecs[13] = mk(0, 1,  8, 1, 1,  1,  8,  0, 1);
    vecs[14] = mk(0, 1, 10, 1, 1,  1, 10,  0, 1);
    vecs[15] = mk(0, 1, 20, 1, 1,  1, 20,  0, 1);
    vecs[16] = mk(0, 1, 30, 1, 1,  1, 30,  0, 1);
    vecs[17] = mk(0, 0,  0, 0, 1,  0, 30,  0, 1);
    vecs[18] = mk(0, 1, 50, 0, 1,  0, 30,  0, 1);
    vecs[19] = mk(0, 1, 40, 0, 1,  0, 30,  0, 1);
    vecs[20] = mk(1, 0,  0, 0, 1,  0,  0,  0, 0);
    vecs[21] = mk(0, 1,  5, 0, 1,  0,  0,  0, 0);
    vecs[22] = mk(0, 1, 15, 1, 1,  1, 15,  5, 2);
    vecs[23] = mk(0, 0,  0, 0, 1,  0, 15,  5, 2);

    for (int i = 0; i < 24; i++) begin
      step(vecs[i].rst, vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].mr);
      check($sformatf("vec%0d_m_valid", i), 64'(m_valid), 64'(vecs[i].emv));
      check($sformatf("vec%0d_m_largest", i), 64'(m_largest), 64'(vecs[i].el));
      check($sformatf("vec%0d_m_second", i), 64'(m_second), 64'(vecs[i].es));
      check($sformatf("vec%0d_m_count", i), 64'(m_count), 64'(vecs[i].ec));
    end

    // Randomized traffic with mixed small (duplicate-heavy) and full-range data.
    for (int n = 0; n < 4000; n++) begin
      bit          r_rst, r_v, r_l, r_mr;
      logic [31:0] r_d;
      r_rst = ($urandom_range(0, 299) == 0);
      r_v   = ($urandom_range(0, 3) != 0);
      r_d   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : 32'($urandom);
      r_l   = ($urandom_range(0, 4) == 0);
      r_mr  = ($urandom_range(0, 3) != 0);
      step(r_rst, r_v, r_d, r_l, r_mr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
